// File: rtl/sha256_target_compare_if.sv
// Bus bundle for sha256_target_compare.
//   Control side : start, digest_addr, target_addr, result_addr -> block
//                  done, hit, equal                             <- block
//   Memory side  : mem_clk, mem_we, mem_addr, mem_write_data    <- block
//                  mem_read_data (registered read, 1 cycle)     -> block
// The comparator itself takes the slave modport; whoever drives the control
// inputs and provides the memory takes the master modport.
interface sha256_target_compare_if;
  logic        start;
  logic [15:0] digest_addr;
  logic [15:0] target_addr;
  logic [15:0] result_addr;
  logic        done;
  logic        hit;
  logic        equal;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  start, digest_addr, target_addr, result_addr, mem_read_data,
    output done, hit, equal, mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport master (
    output start, digest_addr, target_addr, result_addr, mem_read_data,
    input  done, hit, equal, mem_clk, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/sha256_target_compare.sv
// sha256_target_compare: proof-of-work hit test (digest < target).
// Reads DIGEST_WORDS target words, then DIGEST_WORDS digest words over a
// single-port registered-read memory, comparing most significant word first.
// Fixed latency: done falls the cycle after start and rises again
// 2*(DIGEST_WORDS+1)+1 cycles after start was sampled (+1 with write-back).
// Ports:
//   clk   - system clock, forwarded as bus.mem_clk
//   reset - asynchronous, active-high
//   bus   - sha256_target_compare_if.slave (control + memory signals)
// Optional feature macro: RESULT_WB_EN -- adds a WB state that writes
//   {30'b0, equal, hit} to result_addr before returning to IDLE.
module sha256_target_compare #(
  parameter int DIGEST_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  sha256_target_compare_if.slave   bus
);

  localparam int IW = $clog2(DIGEST_WORDS + 1);
  localparam int SW = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGEST_WORDS);

`ifdef RESULT_WB_EN
  typedef enum logic [1:0] {IDLE, RD_TGT, RD_DIG, WB} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD_TGT, RD_DIG} state_t;
`endif

  state_t state_q, state_d;

  logic [IW-1:0]                   idx_q;
  logic [15:0]                     dbase_q, tbase_q;
  logic [DIGEST_WORDS-1:0][31:0]   tgt_q;
  logic                            decided_q, decided_d;
  logic                            hit_q, hit_d;
  logic                            equal_q;
  logic [IW-1:0]                   cap_idx;
  logic [15:0]                     idx_ext;
  logic [31:0]                     tgt_w;

`ifdef RESULT_WB_EN
  logic [15:0] rbase_q;
`else
  logic unused_result_addr;
  assign unused_result_addr = ^bus.result_addr;
`endif

  // Word arriving on mem_read_data belongs to the address issued last cycle.
  assign cap_idx = idx_q - 1'b1;
  assign idx_ext = {{(16-IW){1'b0}}, idx_q};
  assign tgt_w   = tgt_q[cap_idx[SW-1:0]];

  assign bus.mem_clk = clk;
  assign bus.hit     = hit_q;
  assign bus.equal   = equal_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.start)     state_d = RD_TGT;
      RD_TGT: if (idx_q == LAST) state_d = RD_DIG;
`ifdef RESULT_WB_EN
      RD_DIG: if (idx_q == LAST) state_d = WB;
      WB:                        state_d = IDLE;
`else
      RD_DIG: if (idx_q == LAST) state_d = IDLE;
`endif
      default:                   state_d = IDLE;
    endcase
  end

  // Outputs: done/memory controls decoded from state and index.
  always_comb begin
    bus.done           = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = 16'h0000;
    bus.mem_write_data = 32'h0;
    case (state_q)
      IDLE:   bus.done = 1'b1;
      RD_TGT: if (idx_q < LAST) bus.mem_addr = tbase_q + idx_ext;
      RD_DIG: if (idx_q < LAST) bus.mem_addr = dbase_q + idx_ext;
`ifdef RESULT_WB_EN
      WB: begin
        bus.mem_we         = 1'b1;
        bus.mem_addr       = rbase_q;
        bus.mem_write_data = {30'b0, equal_q, hit_q};
      end
`endif
      default: ;
    endcase
  end

  // First differing word (MSW first) fixes the decision; later words ignored.
  always_comb begin
    decided_d = decided_q;
    hit_d     = hit_q;
    if (state_q == RD_DIG && idx_q != '0 && !decided_q &&
        bus.mem_read_data != tgt_w) begin
      decided_d = 1'b1;
      hit_d     = bus.mem_read_data < tgt_w;
    end
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      dbase_q   <= 16'h0;
      tbase_q   <= 16'h0;
      tgt_q     <= '0;
      decided_q <= 1'b0;
      hit_q     <= 1'b0;
      equal_q   <= 1'b0;
`ifdef RESULT_WB_EN
      rbase_q   <= 16'h0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          dbase_q   <= bus.digest_addr;
          tbase_q   <= bus.target_addr;
`ifdef RESULT_WB_EN
          rbase_q   <= bus.result_addr;
`endif
          hit_q     <= 1'b0;
          equal_q   <= 1'b0;
          decided_q <= 1'b0;
          idx_q     <= '0;
        end
        RD_TGT: begin
          if (idx_q != '0) tgt_q[cap_idx[SW-1:0]] <= bus.mem_read_data;
          idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
        RD_DIG: begin
          decided_q <= decided_d;
          hit_q     <= hit_d;
          if (idx_q == LAST) equal_q <= ~decided_d;
          idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sha256_target_compare.md
Name: sha256_target_compare

Overview:
- Downstream consumer of the SHA-256 core. Once the core reports done, this block reads the 8-word digest the core wrote to shared memory, reads a 256-bit target from the same memory, and decides whether digest < target (the proof-of-work hit test).
- Uses the same single-port, registered-read memory bus as the hash core. It is the decision stage of the nonce-search loop.

Parameters:
- DIGEST_WORDS, 8, number of 32-bit words compared (1..8). Word 0 (h0) is most significant.

Ports:
- clk  input  1  system clock; also drives mem_clk
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin comparison; sampled only in IDLE
- digest_addr  input  16  word address of digest word 0
- target_addr  input  16  word address of target word 0
- result_addr  input  16  word address for result write-back (used only with RESULT_WB_EN)
- done  output  1  high while in IDLE
- hit  output  1  digest < target (unsigned, 256-bit big-word-endian)
- equal  output  1  digest == target
- mem_clk  output  1  equals clk
- mem_we  output  1  memory write enable
- mem_addr  output  16  memory word address
- mem_write_data  output  32  memory write data
- mem_read_data  input  32  memory read data, valid one cycle after address presented

Behaviour:
- Reset (async, active-high):
  - state=IDLE; hit=0, equal=0, mem_we=0, mem_write_data=0.
  - Internal index and decided flag are cleared.
  - Reset asserted mid-operation aborts immediately; no partial write occurs.
- States: IDLE, RD_TGT, RD_DIG, WB (WB only exists with RESULT_WB_EN).
- IDLE:
  - done=1 and mem_we=0.
  - On start=1: latch digest_addr, target_addr and result_addr; clear hit, equal, decided and idx; go to RD_TGT.
- RD_TGT, for idx = 0..DIGEST_WORDS:
  - When idx < DIGEST_WORDS, present mem_addr = target_addr + idx.
  - When idx >= 1, capture tgt[idx-1] from mem_read_data.
  - idx increments every cycle.
  - After the idx = DIGEST_WORDS cycle: idx <= 0 and go to RD_DIG.
- RD_DIG, for idx = 0..DIGEST_WORDS:
  - Same address/capture pipeline, using digest_addr.
  - On each capture, when decided=0 and dig != tgt[idx-1]: set decided=1 and set hit <= (dig < tgt[idx-1]) as a 32-bit unsigned compare.
  - Words after the first differing word never change hit.
  - After the final capture: equal <= ~decided_next. Then go to WB, or to IDLE if the feature is off.
- Fixed latency, no early exit. The cycle start is sampled in IDLE is cycle 0; done rises at cycle 2*(DIGEST_WORDS+1)+1, which is 19 for the default.
- hit and equal:
  - Valid whenever done=1 after a completed run.
  - Hold until the next start.
  - hit and equal are never both 1.
- start while not in IDLE is ignored.
- Address arithmetic is 16-bit modulo: base + idx wraps past 16'hFFFF.
- mem_we is 0 in every state except WB.

Optional Feature:
- Macro: RESULT_WB_EN.
- Defined:
  - After RD_DIG, enter WB for exactly one cycle with mem_we=1, mem_addr=result_addr, and mem_write_data = {30'b0, equal, hit} using the final values.
  - Then go to IDLE. done rises one cycle later (20 for the default).
- Not defined: there is no WB state, the block never writes memory, and result_addr is unused.

Test Plan:
- Digest word0 = 0x00000001, target word0 = 0x00000002, all remaining words 0xFFFFFFFF in both -> hit=1, equal=0, done at cycle 19.
- Digest word0 = 0x00000003, target word0 = 0x00000002, digest word1 = 0, target word1 = 0xFFFFFFFF -> hit=0, equal=0; the opposite outcome at word 1 must not override the decision at word 0.
- Digest identical to target (8 × 0xDEADBEEF) -> hit=0, equal=1.
- Only word 7 differs: digest 0x0000000F, target 0x00000010 -> hit=1. Check mem_addr sequence target_addr..+7, then digest_addr..+7, including target_addr = 16'hFFFE wrapping to 0x0000.
- Assert reset during RD_DIG at cycle 14 -> next cycle done=1, hit=0, equal=0, mem_we=0. start pulsed mid-run in a separate run has no effect.
- With RESULT_WB_EN and the hit case above: exactly one write at cycle 19 to result_addr with data 0x00000001, done at cycle 20. Without the macro, mem_we stays 0 for the entire run.
